// File: rtl/axi_lite_arbiter_2x1_pkg.sv
// ----------------------------------------------------------------------------
// axi_lite_arbiter_2x1_pkg : shared FSM encodings and AXI response codes.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package axi_lite_arbiter_2x1_pkg;

  localparam int unsigned CPU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/axi_lite_arbiter_2x1_sel.sv
// ----------------------------------------------------------------------------
// axi_lite_arbiter_2x1_sel : combinational 2:1 grant select (ARB_RR_EN = RR).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_lite_arbiter_2x1_sel
  import axi_lite_arbiter_2x1_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_o
);

  always_comb begin
    gnt_o = last_grant_i;
    unique case (req_i)
      2'b01: gnt_o = 1'b0;
      2'b10: gnt_o = 1'b1;
      2'b11: begin
`ifdef ARB_RR_EN
        gnt_o = ~last_grant_i;
`else
        // LSU keeps fixed priority on contention
        gnt_o = 1'b1;
`endif
      end
      default: gnt_o = last_grant_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/axi_lite_arbiter_2x1.sv
// ----------------------------------------------------------------------------
// axi_lite_arbiter_2x1 : 2-master/1-slave AXI-Lite arbiter, one outstanding txn.
// Rev 1.0 -- ARB_RR_EN selects round-robin contention (default: m1 priority).
// ----------------------------------------------------------------------------
`default_nettype none

module axi_lite_arbiter_2x1
  import axi_lite_arbiter_2x1_pkg::*;
#(
  parameter int unsigned ADDR_W = CPU_WIDTH,
  parameter int unsigned DATA_W = CPU_WIDTH
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  // master 0 (IFU)
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  output logic [1:0]          m0_bresp,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  // master 1 (LSU)
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  output logic [1:0]          m1_bresp,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  // slave
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  // status
  output logic                o_owner,
  output logic                o_busy
);

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;

  logic [1:0] req;
  logic       gnt;
  logic       gnt_is_wr;
  logic       rd_act, wr_act;
  logic       own_awvalid, own_wvalid, own_bready, own_arvalid, own_rready;
  logic       s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;

  assign req[0]    = m0_arvalid | m0_awvalid;
  assign req[1]    = m1_arvalid | m1_awvalid;
  assign gnt_is_wr = gnt ? m1_awvalid : m0_awvalid;

  axi_lite_arbiter_2x1_sel u_sel (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .gnt_o        (gnt)
  );

  assign rd_act = (state_q == ST_RD);
  assign wr_act = (state_q == ST_WR);

  assign own_awvalid = owner_q ? m1_awvalid : m0_awvalid;
  assign own_wvalid  = owner_q ? m1_wvalid  : m0_wvalid;
  assign own_bready  = owner_q ? m1_bready  : m0_bready;
  assign own_arvalid = owner_q ? m1_arvalid : m0_arvalid;
  assign own_rready  = owner_q ? m1_rready  : m0_rready;

  // Request channels: owner's payload muxed through, valids masked once accepted
  assign s_awaddr  = owner_q ? m1_awaddr : m0_awaddr;
  assign s_wdata   = owner_q ? m1_wdata  : m0_wdata;
  assign s_wstrb   = owner_q ? m1_wstrb  : m0_wstrb;
  assign s_araddr  = owner_q ? m1_araddr : m0_araddr;
  assign s_awvalid = wr_act & own_awvalid & ~aw_done_q;
  assign s_wvalid  = wr_act & own_wvalid  & ~w_done_q;
  assign s_arvalid = rd_act & own_arvalid & ~ar_done_q;
  assign s_bready  = wr_act & own_bready;
  assign s_rready  = rd_act & own_rready;

  assign s_aw_hs = s_awvalid & s_awready;
  assign s_w_hs  = s_wvalid  & s_wready;
  assign s_b_hs  = s_bvalid  & s_bready;
  assign s_ar_hs = s_arvalid & s_arready;
  assign s_r_hs  = s_rvalid  & s_rready;

  assign m0_awready = s_aw_hs & ~owner_q;
  assign m1_awready = s_aw_hs &  owner_q;
  assign m0_wready  = s_w_hs  & ~owner_q;
  assign m1_wready  = s_w_hs  &  owner_q;
  assign m0_arready = s_ar_hs & ~owner_q;
  assign m1_arready = s_ar_hs &  owner_q;
  assign m0_bvalid  = wr_act & s_bvalid & ~owner_q;
  assign m1_bvalid  = wr_act & s_bvalid &  owner_q;
  assign m0_rvalid  = rd_act & s_rvalid & ~owner_q;
  assign m1_rvalid  = rd_act & s_rvalid &  owner_q;

  assign m0_bresp = s_bresp;
  assign m1_bresp = s_bresp;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;

  assign o_owner = owner_q;
  assign o_busy  = (state_q != ST_IDLE);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ar_done_d    = ar_done_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d      = gnt;
          last_grant_d = gnt;
          state_d      = gnt_is_wr ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        if (s_ar_hs) ar_done_d = 1'b1;
        if (s_r_hs) begin
          state_d   = ST_IDLE;
          ar_done_d = 1'b0;
        end
      end
      ST_WR: begin
        if (s_aw_hs) aw_done_d = 1'b1;
        if (s_w_hs)  w_done_d  = 1'b1;
        if (s_b_hs) begin
          state_d   = ST_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b1;
      last_grant_q <= 1'b1;
      ar_done_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ar_done_q    <= ar_done_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_arbiter_2x1.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_arbiter_2x1 : directed self-checking bench for the 2x1 arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axi_lite_arbiter_2x1;
  import axi_lite_arbiter_2x1_pkg::*;

  logic clk, rst_n;

  logic [1:0][31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [1:0][3:0]  m_wstrb;
  logic [1:0][1:0]  m_bresp, m_rresp;
  logic [1:0]       m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]       m_arvalid, m_arready, m_rvalid, m_rready;

  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        o_owner, o_busy;

  int n_cmp = 0;
  int n_err = 0;

  axi_lite_arbiter_2x1 dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .m0_awaddr(m_awaddr[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
    .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
    .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
    .m0_araddr(m_araddr[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
    .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
    .m1_awaddr(m_awaddr[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
    .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
    .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
    .m1_araddr(m_araddr[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
    .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .o_owner(o_owner), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          dly;   // read: R latency; write: cycles W leads AW
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] hs_vec();
    return {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
            m_arready, m_awready, m_wready, m_rvalid, m_bvalid};
  endfunction

  // Entered and left one time unit after a rising edge.
  task automatic do_read(input logic m, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input int lat);
    logic o;
    int   n;
    int   leak;
    o = ~m;
    leak = 0;
    m_araddr[m] = addr; m_arvalid[m] = 1'b1; m_rready[m] = 1'b1;
    s_arready = 1'b1; s_rvalid = 1'b0;
    n = 0;
    #1;
    while (!s_arvalid && n < 20) begin
      tick; #1; n++;
    end
    check("rd_ar_timeout", 64'(n < 20), 1);
    check("rd_owner", o_owner, m);
    check("rd_s_araddr", s_araddr, addr);
    check("rd_m_arready", m_arready[m], 1);
    if (m_arready[o] || m_rvalid[o]) leak++;
    tick;
    m_arvalid[m] = 1'b0;
    for (int i = 0; i < lat; i++) begin
      #1;
      if (s_arvalid || m_arready[o] || m_rvalid[o] || m_rvalid[m]) leak++;
      tick;
    end
    s_rvalid = 1'b1; s_rdata = data; s_rresp = resp;
    #1;
    check("rd_m_rvalid", m_rvalid[m], 1);
    check("rd_m_rdata", m_rdata[m], data);
    check("rd_m_rresp", m_rresp[m], resp);
    check("rd_s_rready", s_rready, 1);
    if (m_arready[o] || m_rvalid[o]) leak++;
    tick;
    s_rvalid = 1'b0; m_rready[m] = 1'b0;
    #1;
    check("rd_busy_after", o_busy, 0);
    check("rd_leak", leak, 0);
    tick;
  endtask

  task automatic do_write(input logic m, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp, input int aw_delay);
    logic        o;
    int          aw_cnt, w_cnt, leak;
    bit          got_b, aw_acc, w_acc;
    logic [31:0] sa, sd;
    logic [3:0]  ss;
    logic [1:0]  br;
    logic        own;
    o = ~m;
    aw_cnt = 0; w_cnt = 0; leak = 0; got_b = 1'b0;
    sa = '0; sd = '0; ss = '0; br = 2'b01; own = o;
    m_awaddr[m] = addr; m_wdata[m] = data; m_wstrb[m] = strb; m_bready[m] = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1; s_bresp = resp;
    for (int c = 0; c < 40 && !got_b; c++) begin
      if (c == 0) m_wvalid[m] = 1'b1;
      if (c == aw_delay) m_awvalid[m] = 1'b1;
      if (aw_cnt > 0 && w_cnt > 0) s_bvalid = 1'b1;
      #1;
      if (s_awvalid && s_awready) begin aw_cnt++; sa = s_awaddr; own = o_owner; end
      if (s_wvalid && s_wready) begin w_cnt++; sd = s_wdata; ss = s_wstrb; end
      if (m_awready[o] || m_wready[o] || m_bvalid[o] || s_arvalid) leak++;
      aw_acc = m_awvalid[m] && m_awready[m];
      w_acc  = m_wvalid[m] && m_wready[m];
      if (m_bvalid[m] && m_bready[m]) begin got_b = 1'b1; br = m_bresp[m]; end
      tick;
      if (aw_acc) m_awvalid[m] = 1'b0;
      if (w_acc)  m_wvalid[m] = 1'b0;
    end
    s_bvalid = 1'b0; m_bready[m] = 1'b0;
    check("wr_b_timeout", got_b, 1);
    check("wr_aw_count", aw_cnt, 1);
    check("wr_w_count", w_cnt, 1);
    check("wr_owner", own, m);
    check("wr_s_awaddr", sa, addr);
    check("wr_s_wdata", sd, data);
    check("wr_s_wstrb", ss, strb);
    check("wr_bresp", br, resp);
    check("wr_leak", leak, 0);
    #1;
    check("wr_busy_after", o_busy, 0);
    tick;
  endtask

  initial begin
    logic first, second;
    tbl[0] = '{1'b0, 1'b0, 32'ha000_2000, 32'h0000_1234, 4'h0, RESP_OKAY,   3};
    tbl[1] = '{1'b1, 1'b0, 32'h0200_bff8, 32'hcafe_f00d, 4'h0, RESP_SLVERR, 0};
    tbl[2] = '{1'b0, 1'b1, 32'h0200_4000, 32'h1122_3344, 4'h3, RESP_OKAY,   0};
    tbl[3] = '{1'b1, 1'b1, 32'ha000_0010, 32'hdead_beef, 4'hf, RESP_OKAY,   2};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0ffc, 32'h8765_4321, 4'h0, 2'b11,       1};
    tbl[5] = '{1'b0, 1'b1, 32'h0200_0008, 32'h0f0f_a5a5, 4'hc, RESP_SLVERR, 1};
    tbl[6] = '{1'b1, 1'b1, 32'h0200_0010, 32'h7777_0001, 4'h1, 2'b11,       0};

    rst_n = 1'b0;
    m_awaddr = '0; m_wdata = '0; m_araddr = '0; m_wstrb = '0;
    m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
    s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;

    tick; tick;
    #1;
    check("rst_handshakes", hs_vec(), 0);
    check("rst_owner", o_owner, 1);
    check("rst_busy", o_busy, 0);
    rst_n = 1'b1;
    tick;
    #1;
    check("post_rst_handshakes", hs_vec(), 0);
    check("post_rst_busy", o_busy, 0);
    tick;

    // Contention with last_grant=1 straight out of reset
`ifdef ARB_RR_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    second = ~first;
    m_araddr[0] = 32'h1000_0000; m_araddr[1] = 32'h2000_0000;
    m_arvalid = 2'b11;
    do_read(first,  first  ? 32'h2000_0000 : 32'h1000_0000, 32'h0000_0a0a, RESP_OKAY, 1);
    do_read(second, second ? 32'h2000_0000 : 32'h1000_0000, 32'h0000_0b0b, RESP_OKAY, 0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].wr)
        do_write(tbl[i].m, tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].resp, tbl[i].dly);
      else
        do_read(tbl[i].m, tbl[i].addr, tbl[i].data, tbl[i].resp, tbl[i].dly);
    end

    // Same-master priority: pending read must not reach the slave during the write
    m_araddr[0] = 32'h0000_3000; m_arvalid[0] = 1'b1;
    do_write(1'b0, 32'h0000_3004, 32'h0123_4567, 4'hf, RESP_OKAY, 0);
    do_read(1'b0, 32'h0000_3000, 32'h89ab_cdef, RESP_OKAY, 0);

    // Backpressure on R while m1 waits
    m_araddr[0] = 32'h0000_1000; m_arvalid[0] = 1'b1; m_rready[0] = 1'b0; s_arready = 1'b1;
    tick; #1;
    check("bp_s_arvalid", s_arvalid, 1);
    tick;
    m_arvalid[0] = 1'b0;
    m_araddr[1] = 32'h0000_2000; m_arvalid[1] = 1'b1;
    s_rvalid = 1'b1; s_rdata = 32'h5a5a_0001; s_rresp = RESP_OKAY;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_s_rready", s_rready, 0);
      check("bp_busy", o_busy, 1);
      check("bp_m1_stall", {m_arready[1], m_rvalid[1], s_arvalid}, 0);
      tick;
    end
    m_rready[0] = 1'b1;
    #1;
    check("bp_release_rready", s_rready, 1);
    check("bp_rdata", m_rdata[0], 32'h5a5a_0001);
    tick;
    s_rvalid = 1'b0; m_rready[0] = 1'b0;
    do_read(1'b1, 32'h0000_2000, 32'h5a5a_0002, RESP_OKAY, 0);

    // Reset mid-WR after the AW handshake
    m_awaddr[0] = 32'h0200_0000; m_wdata[0] = 32'h0bad_f00d; m_wstrb[0] = 4'hf;
    m_awvalid[0] = 1'b1; m_wvalid[0] = 1'b1; m_bready[0] = 1'b1;
    s_awready = 1'b1; s_wready = 1'b0;
    tick; #1;
    check("mr_s_awvalid", s_awvalid, 1);
    check("mr_s_wvalid", s_wvalid, 1);
    tick;
    // AW valid held past its handshake so the done mask is visible
    #1;
    check("mr_aw_masked", s_awvalid, 0);
    check("mr_w_still", s_wvalid, 1);
    rst_n = 1'b0;
    #1;
    check("mr_rst_handshakes", hs_vec(), 0);
    check("mr_rst_busy", o_busy, 0);
    m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0; m_bready[0] = 1'b0; s_wready = 1'b1;
    tick;
    rst_n = 1'b1;
    #1;
    check("mr_post_handshakes", hs_vec(), 0);
    check("mr_post_owner", o_owner, 1);
    tick;
    do_write(1'b0, 32'h0200_0000, 32'h0bad_f00d, 4'hf, RESP_OKAY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
